// File: rtl/pool_sched.sv
`default_nettype none
// ============================================================================
// Module   : pool_sched
// Brief    : Sequences one POOL feature group. It sends the configuration,
//            issues the GB read addresses and counts the flag writes.
// Revision : 1.0 - initial release
// ============================================================================
module pool_sched #(
    parameter int ADDR_WIDTH = 10,
    parameter int FRM_WIDTH  = 5,
    parameter int ROW_WIDTH  = 6
) (
    input  logic                  Clk,
    input  logic                  rst_n,
    input  logic                  CCUPOOL_start,
    input  logic [FRM_WIDTH-1:0]  CCUPOOL_num_frame,
    input  logic [ROW_WIDTH-1:0]  CCUPOOL_num_row,
    input  logic [ADDR_WIDTH-1:0] CCUPOOL_base_addr,
    input  logic                  CCUPOOL_stride,
    input  logic                  CCUPOOL_valfrmpool,
    output logic                  POOLCCU_busy,
    output logic                  POOLCCU_done,
    output logic                  CFGPOOL_val,
    input  logic                  POOLCFG_rdy,
    output logic                  CFGPOOL_stride,
    output logic                  CFGPOOL_valfrmpool,
    output logic                  GBPOOL_addr_val,
    input  logic                  GBPOOL_addr_rdy,
    output logic [ADDR_WIDTH-1:0] GBPOOL_addr,
    input  logic                  BF_flg_val,
    input  logic                  BF_flg_rdy
);

    localparam int c_CNT_W = FRM_WIDTH + ROW_WIDTH + 2;

    localparam logic [2:0] c_IDLE  = 3'd0;
    localparam logic [2:0] c_CFG   = 3'd1;
    localparam logic [2:0] c_RD    = 3'd2;
    localparam logic [2:0] c_DRAIN = 3'd3;
    localparam logic [2:0] c_DONE  = 3'd4;

    localparam logic [FRM_WIDTH-1:0]  c_FRM_ONE = FRM_WIDTH'(1);
    localparam logic [FRM_WIDTH-1:0]  c_FRM_TWO = FRM_WIDTH'(2);
    localparam logic [ROW_WIDTH-1:0]  c_ROW_ONE = ROW_WIDTH'(1);

    logic [2:0]            r_state;
    logic [FRM_WIDTH-1:0]  r_nf;
    logic [ROW_WIDTH-1:0]  r_nr;
    logic [ADDR_WIDTH-1:0] r_base;
    logic                  r_stride;
    logic                  r_vfp;
    logic [ROW_WIDTH-1:0]  r_row;
    logic [FRM_WIDTH-1:0]  r_frm;
    logic                  r_ph;
    logic [ADDR_WIDTH-1:0] r_fbase;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [c_CNT_W-1:0]    r_cnt;

    logic [FRM_WIDTH:0]    w_n;
    logic [ROW_WIDTH:0]    w_r;
    logic [FRM_WIDTH:0]    w_fo;
    logic [ROW_WIDTH:0]    w_ro;
    logic [c_CNT_W-1:0]    w_exp;
    logic [ADDR_WIDTH-1:0] w_rlen;
    logic                  w_paired;
    logic                  w_row_end;
    logic                  w_last;
    logic                  w_busy;
    logic                  w_inc;
    logic [c_CNT_W-1:0]    w_cnt_n;
    logic [ROW_WIDTH-1:0]  w_row_n;
    logic [FRM_WIDTH-1:0]  w_frm_n;
    logic                  w_ph_n;
    logic [ADDR_WIDTH-1:0] w_fbase_n;
    logic [ADDR_WIDTH-1:0] w_addr_n;

    assign w_n    = {1'b0, r_nf} + {{FRM_WIDTH{1'b0}}, 1'b1};
    assign w_r    = {1'b0, r_nr} + {{ROW_WIDTH{1'b0}}, 1'b1};
    assign w_fo   = r_vfp    ? ((w_n + {{FRM_WIDTH{1'b0}}, 1'b1}) >> 1) : w_n;
    assign w_ro   = r_stride ? ((w_r + {{ROW_WIDTH{1'b0}}, 1'b1}) >> 1) : w_r;
    assign w_exp  = c_CNT_W'(w_fo) * c_CNT_W'(w_ro);
    assign w_rlen = ADDR_WIDTH'(w_r);

    // A frame has a partner unless it is the trailing odd one.
    assign w_paired  = r_vfp && (r_frm != r_nf);
    assign w_row_end = (r_row == r_nr);
    assign w_last    = w_row_end && (w_paired ? (r_ph && ((r_frm + c_FRM_ONE) == r_nf))
                                              : (r_frm == r_nf));

    assign w_busy  = (r_state == c_CFG) || (r_state == c_RD) || (r_state == c_DRAIN);
    assign w_inc   = w_busy && BF_flg_val && BF_flg_rdy;
    assign w_cnt_n = r_cnt + {{(c_CNT_W-1){1'b0}}, w_inc};

    always_comb begin
        w_row_n   = r_row;
        w_frm_n   = r_frm;
        w_ph_n    = r_ph;
        w_fbase_n = r_fbase;
        if (w_paired && !r_ph) begin
            w_ph_n = 1'b1;
        end else begin
            w_ph_n = 1'b0;
            if (w_row_end) begin
                w_row_n   = '0;
                w_fbase_n = r_fbase + (w_paired ? (w_rlen << 1) : w_rlen);
                w_frm_n   = r_frm + (w_paired ? c_FRM_TWO : c_FRM_ONE);
            end else begin
                w_row_n = r_row + c_ROW_ONE;
            end
        end
        w_addr_n = w_fbase_n + (w_ph_n ? w_rlen : '0) + ADDR_WIDTH'(w_row_n);
    end

    always_ff @(posedge Clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= c_IDLE;
            r_nf     <= '0;
            r_nr     <= '0;
            r_base   <= '0;
            r_stride <= 1'b0;
            r_vfp    <= 1'b0;
            r_row    <= '0;
            r_frm    <= '0;
            r_ph     <= 1'b0;
            r_fbase  <= '0;
            r_addr   <= '0;
            r_cnt    <= '0;
        end else begin
            r_cnt <= w_busy ? w_cnt_n : '0;
            case (r_state)
                c_IDLE: begin
                    if (CCUPOOL_start) begin
                        r_nf     <= CCUPOOL_num_frame;
                        r_nr     <= CCUPOOL_num_row;
                        r_base   <= CCUPOOL_base_addr;
                        r_stride <= CCUPOOL_stride;
                        r_vfp    <= CCUPOOL_valfrmpool;
                        r_state  <= c_CFG;
                    end
                end
                c_CFG: begin
                    if (POOLCFG_rdy) begin
                        r_row   <= '0;
                        r_frm   <= '0;
                        r_ph    <= 1'b0;
                        r_fbase <= r_base;
                        r_addr  <= r_base;
                        r_state <= c_RD;
                    end
                end
                c_RD: begin
                    if (GBPOOL_addr_rdy) begin
                        if (w_last) begin
                            r_state <= c_DRAIN;
                        end else begin
                            r_row   <= w_row_n;
                            r_frm   <= w_frm_n;
                            r_ph    <= w_ph_n;
                            r_fbase <= w_fbase_n;
                            r_addr  <= w_addr_n;
                        end
                    end
                end
                c_DRAIN: begin
                    // Looking at the incoming handshake lets done follow the last flag by one cycle.
                    if (w_cnt_n >= w_exp) begin
                        r_state <= c_DONE;
                    end
                end
                c_DONE:  r_state <= c_IDLE;
                default: r_state <= c_IDLE;
            endcase
        end
    end

    assign POOLCCU_busy       = w_busy;
    assign POOLCCU_done       = (r_state == c_DONE);
    assign CFGPOOL_val        = (r_state == c_CFG);
    assign CFGPOOL_stride     = r_stride;
    assign CFGPOOL_valfrmpool = r_vfp;
    assign GBPOOL_addr_val    = (r_state == c_RD);
    assign GBPOOL_addr        = r_addr;

endmodule
`default_nettype wire

// File: tb/tb_pool_sched.sv
`default_nettype none
// ============================================================================
// Module   : tb_pool_sched
// Brief    : Randomized bench for pool_sched with a queue-based reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pool_sched;
    localparam int AW = 10;
    localparam int FW = 5;
    localparam int RW = 6;

    logic          Clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          CCUPOOL_start = 1'b0;
    logic [FW-1:0] CCUPOOL_num_frame = '0;
    logic [RW-1:0] CCUPOOL_num_row = '0;
    logic [AW-1:0] CCUPOOL_base_addr = '0;
    logic          CCUPOOL_stride = 1'b0;
    logic          CCUPOOL_valfrmpool = 1'b0;
    logic          POOLCFG_rdy = 1'b0;
    logic          GBPOOL_addr_rdy = 1'b0;
    logic          BF_flg_val = 1'b0;
    logic          BF_flg_rdy = 1'b0;
    logic          POOLCCU_busy, POOLCCU_done, CFGPOOL_val, CFGPOOL_stride;
    logic          CFGPOOL_valfrmpool, GBPOOL_addr_val;
    logic [AW-1:0] GBPOOL_addr;

    pool_sched #(.ADDR_WIDTH(AW), .FRM_WIDTH(FW), .ROW_WIDTH(RW)) dut (
        .Clk(Clk), .rst_n(rst_n),
        .CCUPOOL_start(CCUPOOL_start), .CCUPOOL_num_frame(CCUPOOL_num_frame),
        .CCUPOOL_num_row(CCUPOOL_num_row), .CCUPOOL_base_addr(CCUPOOL_base_addr),
        .CCUPOOL_stride(CCUPOOL_stride), .CCUPOOL_valfrmpool(CCUPOOL_valfrmpool),
        .POOLCCU_busy(POOLCCU_busy), .POOLCCU_done(POOLCCU_done),
        .CFGPOOL_val(CFGPOOL_val), .POOLCFG_rdy(POOLCFG_rdy),
        .CFGPOOL_stride(CFGPOOL_stride), .CFGPOOL_valfrmpool(CFGPOOL_valfrmpool),
        .GBPOOL_addr_val(GBPOOL_addr_val), .GBPOOL_addr_rdy(GBPOOL_addr_rdy),
        .GBPOOL_addr(GBPOOL_addr), .BF_flg_val(BF_flg_val), .BF_flg_rdy(BF_flg_rdy)
    );

    always #5 Clk = ~Clk;

    int n_vec = 0;
    int n_fail = 0;
    int cyc = 0;
    always @(posedge Clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input longint act, input longint exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Reference model: the expected address list plus handshake bookkeeping.
    logic [AW-1:0] m_q[$];
    logic [AW-1:0] log_q[$];
    int  m_E = 0, m_flags = 0, t_a = -1, t_f = -1, done_at = -1, n_done = 0;
    bit  m_busy = 0, m_cfgv = 0, m_addrv = 0, m_done = 0, m_stride = 0, m_vfp = 0;
    bit  busy_p, done_p;
    logic [AW-1:0] p_addr = '0;
    logic [AW-1:0] e_addr;

    function automatic void build_q(input int nf, input int nr, input int base, input bit vf);
        int n, r;
        n = nf + 1;
        r = nr + 1;
        m_q.delete();
        if (!vf) begin
            for (int f = 0; f < n; f++)
                for (int j = 0; j < r; j++) m_q.push_back(AW'(base + f * r + j));
        end else begin
            for (int f = 0; f < n; f += 2) begin
                for (int j = 0; j < r; j++) begin
                    m_q.push_back(AW'(base + f * r + j));
                    if (f + 1 < n) m_q.push_back(AW'(base + (f + 1) * r + j));
                end
            end
        end
    endfunction

    always @(posedge Clk) begin
        #1;
        if (!rst_n) begin
            chk("rst_busy", POOLCCU_busy, 0);
            chk("rst_done", POOLCCU_done, 0);
            chk("rst_cfg_val", CFGPOOL_val, 0);
            chk("rst_cfg_stride", CFGPOOL_stride, 0);
            chk("rst_cfg_vfp", CFGPOOL_valfrmpool, 0);
            chk("rst_addr_val", GBPOOL_addr_val, 0);
            chk("rst_addr", GBPOOL_addr, 0);
            m_busy = 0; m_cfgv = 0; m_addrv = 0; m_done = 0;
            m_stride = 0; m_vfp = 0; m_flags = 0; m_E = 0;
            t_a = -1; t_f = -1; done_at = -1;
            m_q.delete();
            p_addr = '0;
        end else begin
            busy_p = m_busy;
            done_p = m_done;
            if (m_addrv && GBPOOL_addr_rdy) begin
                log_q.push_back(p_addr);
                void'(m_q.pop_front());
                if (m_q.size() == 0) begin
                    m_addrv = 0;
                    t_a = cyc;
                end
            end
            if (m_cfgv && POOLCFG_rdy) begin
                m_cfgv  = 0;
                m_addrv = 1;
            end
            if (busy_p && BF_flg_val && BF_flg_rdy) begin
                m_flags++;
                if (m_flags == m_E) t_f = cyc;
            end
            if (!busy_p && !done_p && CCUPOOL_start) begin
                build_q(int'(CCUPOOL_num_frame), int'(CCUPOOL_num_row),
                        int'(CCUPOOL_base_addr), CCUPOOL_valfrmpool);
                m_stride = CCUPOOL_stride;
                m_vfp    = CCUPOOL_valfrmpool;
                m_E = (CCUPOOL_valfrmpool ? (int'(CCUPOOL_num_frame) + 2) / 2 : int'(CCUPOOL_num_frame) + 1)
                    * (CCUPOOL_stride ? (int'(CCUPOOL_num_row) + 2) / 2 : int'(CCUPOOL_num_row) + 1);
                m_busy = 1; m_cfgv = 1; m_flags = 0;
                t_a = -1; t_f = -1; done_at = -1;
            end
            m_done = 0;
            if (done_at < 0 && t_a >= 0 && t_f >= 0)
                done_at = (t_f > t_a) ? t_f : t_a + 1;
            if (done_at >= 0 && done_at == cyc) begin
                m_done = 1; m_busy = 0;
                done_at = -1; t_a = -1; t_f = -1;
                n_done++;
            end
            chk("busy", POOLCCU_busy, m_busy);
            chk("done", POOLCCU_done, m_done);
            chk("cfg_val", CFGPOOL_val, m_cfgv);
            chk("addr_val", GBPOOL_addr_val, m_addrv);
            if (m_addrv) begin
                e_addr = m_q[0];
                chk("addr", GBPOOL_addr, e_addr);
            end
            if (m_busy) begin
                chk("cfg_stride", CFGPOOL_stride, m_stride);
                chk("cfg_vfp", CFGPOOL_valfrmpool, m_vfp);
            end
            p_addr = GBPOOL_addr;
        end
    end

    task automatic run_op(input int nf, input int nr, input int base, input bit st, input bit vf,
                          input int rdy_pct, input int flg_pct, input int abort_at);
        int budget, d0;
        bit stop;
        @(negedge Clk);
        log_q.delete();
        d0 = n_done;
        CCUPOOL_num_frame  = FW'(nf);
        CCUPOOL_num_row    = RW'(nr);
        CCUPOOL_base_addr  = AW'(base);
        CCUPOOL_stride     = st;
        CCUPOOL_valfrmpool = vf;
        CCUPOOL_start      = 1'b1;
        @(negedge Clk);
        CCUPOOL_start      = 1'b0;
        CCUPOOL_num_frame  = FW'($urandom);
        CCUPOOL_num_row    = RW'($urandom);
        CCUPOOL_base_addr  = AW'($urandom);
        CCUPOOL_stride     = 1'($urandom);
        CCUPOOL_valfrmpool = 1'($urandom);
        budget = 0;
        stop = 0;
        while (!stop && n_done == d0 && budget < 20000) begin
            if (abort_at > 0 && m_addrv && m_q.size() <= abort_at) begin
                rst_n = 1'b0;
                CCUPOOL_start = 1'b1;
                repeat (3) @(negedge Clk);
                rst_n = 1'b1;
                stop = 1;
            end else begin
                GBPOOL_addr_rdy = ($urandom_range(99) < rdy_pct);
                POOLCFG_rdy     = ($urandom_range(99) < rdy_pct);
                if (m_busy && m_flags < m_E) begin
                    BF_flg_val = ($urandom_range(99) < flg_pct);
                    BF_flg_rdy = ($urandom_range(3) != 0);
                end else begin
                    BF_flg_val = 1'b0;
                    BF_flg_rdy = 1'b0;
                end
                CCUPOOL_start = m_busy && ($urandom_range(15) == 0);
                @(negedge Clk);
                budget++;
            end
        end
        CCUPOOL_start = 1'b0;
        BF_flg_val = 1'b0;
        BF_flg_rdy = 1'b0;
        if (budget >= 20000) begin
            chk("op_timeout", budget, 0);
            rst_n = 1'b0;
            @(negedge Clk);
            rst_n = 1'b1;
        end
        // Flag traffic while idle must not leak into the next group's count.
        repeat (2) begin
            BF_flg_val = 1'b1;
            BF_flg_rdy = 1'b1;
            @(negedge Clk);
        end
        BF_flg_val = 1'b0;
        BF_flg_rdy = 1'b0;
    endtask

    task automatic chk_log(input string nm, input int e[8], input int n);
        chk({nm, "_len"}, log_q.size(), n);
        for (int i = 0; i < n && i < log_q.size(); i++) chk(nm, log_q[i], e[i]);
    endtask

    initial begin
        int e8[8];
        int d0;
        repeat (3) @(negedge Clk);
        rst_n = 1'b1;

        d0 = n_done;
        run_op(1, 3, 100, 0, 0, 100, 100, 0);
        e8 = '{100, 101, 102, 103, 104, 105, 106, 107};
        chk_log("seq_linear", e8, 8);
        chk("done_once", n_done - d0, 1);

        run_op(1, 2, 0, 0, 1, 100, 60, 0);
        e8 = '{0, 3, 1, 4, 2, 5, 0, 0};
        chk_log("seq_pair", e8, 6);

        run_op(2, 1, 10, 1, 1, 100, 60, 0);
        e8 = '{10, 12, 11, 13, 14, 15, 0, 0};
        chk_log("seq_pair_odd", e8, 6);

        run_op(0, 7, 1020, 0, 0, 70, 50, 0);
        e8 = '{1020, 1021, 1022, 1023, 0, 1, 2, 3};
        chk_log("seq_wrap", e8, 8);

        for (int k = 0; k < 14; k++)
            run_op($urandom_range(0, 6), $urandom_range(0, 9), $urandom_range(0, 1023),
                   1'($urandom), 1'($urandom), $urandom_range(40, 100), $urandom_range(30, 90), 0);

        d0 = n_done;
        run_op(3, 7, 500, 0, 1, 70, 40, 20);
        chk("no_done_on_reset", n_done, d0);
        run_op(1, 3, 200, 0, 0, 100, 80, 0);
        e8 = '{200, 201, 202, 203, 204, 205, 206, 207};
        chk_log("seq_after_reset", e8, 8);

        repeat (4) @(negedge Clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/pool_sched.md
# pool_sched

Sequencer for the POOL datapath of TS3D. On a start pulse from the CCU it pushes the pooling configuration into POOL, then issues the global-buffer read addresses for every frame and row of the current feature group. For frame pooling it interleaves frame pairs. It counts POOL flag-buffer writes and signals completion back to the CCU. It sits between inst_CCU and inst_POOL and replaces ad-hoc CCU control of POOL.

## Interface
- ADDR_WIDTH, 10, GB read-address width
- FRM_WIDTH, 5, frame-count field width
- ROW_WIDTH, 6, row-count field width
- Clk  in  1  clock, all logic on rising edge
- rst_n  in  1  asynchronous, active-low reset
- CCUPOOL_start  in  1  start pulse; sampled only in IDLE
- CCUPOOL_num_frame  in  FRM_WIDTH  frames minus 1 (N = value+1)
- CCUPOOL_num_row  in  ROW_WIDTH  rows per frame minus 1 (R = value+1)
- CCUPOOL_base_addr  in  ADDR_WIDTH  GB address of frame 0, row 0
- CCUPOOL_stride  in  1  0: stride 1, 1: stride 2
- CCUPOOL_valfrmpool  in  1  pool across frame pairs
- POOLCCU_busy  out  1  high from start accept until done
- POOLCCU_done  out  1  one-cycle completion pulse
- CFGPOOL_val / POOLCFG_rdy  out / in  1  config handshake
- CFGPOOL_stride, CFGPOOL_valfrmpool  out  1 each  latched config, stable while CFGPOOL_val
- GBPOOL_addr_val / GBPOOL_addr_rdy  out / in  1  read-request handshake
- GBPOOL_addr  out  ADDR_WIDTH  read address
- BF_flg_val, BF_flg_rdy  in  1 each  POOL flag-write handshake (observed only)

## Operation
- States: IDLE, CFG, RD, DRAIN, DONE.
- IDLE, on CCUPOOL_start: latch all CCUPOOL_* fields, set busy, go to CFG. Start in any other state is ignored.
- CFG: CFGPOOL_val=1 until POOLCFG_rdy, then go to RD.
- RD: present one address per accepted handshake (val&&rdy).
  - Row pointer r = 0..R-1; frame pointer f.
  - valfrmpool=0: order is f=0..N-1 outer, r inner; addr = base + f*R + r.
  - valfrmpool=1: frames in pairs (f, f+1), f = 0,2,4…; per row issue base+f*R+r, then base+(f+1)*R+r.
  - A trailing unpaired frame when N is odd is read row by row alone.
  - Address arithmetic is modulo 2^ADDR_WIDTH; wrap is silent.
  - Keep a running frame-base register (adds R per frame), not a multiplier.
- After the last address is accepted, go to DRAIN.
- Expected output count E = Fo*Ro:
  - Fo = valfrmpool ? (N+1)>>1 : N
  - Ro = stride ? (R+1)>>1 : R
- Output counter increments on every BF_flg_val&&BF_flg_rdy while busy, including handshakes that arrive during CFG or RD.
- DRAIN: when count == E go to DONE. If count already equals E on entry, exit DRAIN the next cycle.
- DONE: done=1 for one cycle, clear busy and counters, return to IDLE.
- Flag handshakes in IDLE are not counted.

## Timing
- Reset values: all outputs 0; state IDLE; counters 0; GBPOOL_addr 0.
- Reset mid-operation aborts immediately to IDLE. No done pulse is emitted.
- Start accepted at edge t:
  - busy=1 and CFGPOOL_val=1 from t+1.
  - POOLCFG_rdy seen at edge t+k: GBPOOL_addr_val=1 with the first address from t+k+1.
- GBPOOL_addr and GBPOOL_addr_val hold until accepted. The next address appears the cycle after accept, giving back-to-back throughput of 1/cycle.
- CFGPOOL_* config outputs hold their latched values throughout busy.
- Last flag handshake completing E at edge t: done=1 and busy=0 at t+1 through t+2 (DONE state lasts one cycle). IDLE accepts a new start at t+2.
- Simultaneous flag handshake and final address accept: both take effect; the count is compared in DRAIN.

## Test plan
- N=2, R=4, base=100, stride=0, valfrmpool=0, rdy always 1 -> addresses 100..107 on consecutive cycles; after 8 flag handshakes, done pulses once.
- N=2, R=3, base=0, valfrmpool=1 -> order 0,3,1,4,2,5; E=3.
- N=3, R=2, base=10, valfrmpool=1, stride=1 -> order 10,12,11,13,14,15; E=2*1=2.
- base=1020, N=1, R=8, ADDR_WIDTH=10 -> addresses 1020..1023, 0..3 (wrap).
- Random GBPOOL_addr_rdy and POOLCFG_rdy stalls -> address and config held stable while stalled; no address skipped or duplicated; start pulses during busy ignored.
- rst_n low mid-RD, then release and restart with new config -> all outputs 0 during reset; new sequence starts from the new base; no stray done pulse.
